// File: rtl/npu_pkg.sv
// Shared NPU constants: default word formats and drain FSM encoding.
package npu_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_SHIFT_DEF = 8;
  localparam int NUM_PE_DEF     = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    DRAIN = ST_DRAIN
  } state_e;

endpackage

// File: rtl/acc_drain_if.sv
// Output word stream of the accumulator drain (valid/ready).
interface acc_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 8
);

  localparam int IW = $clog2(NUM_PE);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IW-1:0]         out_index;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/acc_requant.sv
// Q16.16 -> Q8.8 round-half-up with clamp.
// ACC_DRAIN_RELU_EN: negative results output 0 without flagging saturation.
module acc_requant
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic signed [2*DATA_WIDTH-1:0] acc,
  output logic        [DATA_WIDTH-1:0]   q,
  output logic                           sat
);

  localparam int AW = 2*DATA_WIDTH + 1;

  localparam logic signed [AW-1:0] QMAX =
    AW'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [AW-1:0] QMIN =
    AW'(-(64'sd1 <<< (DATA_WIDTH-1)));
  localparam logic signed [AW-1:0] RND =
    AW'(64'sd1 <<< (FRAC_SHIFT-1));

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sh;

  // One guard bit keeps acc + RND from wrapping at the top of range
  always_comb begin
    ext = {acc[2*DATA_WIDTH-1], acc};
    sum = ext + RND;
    sh  = sum >>> FRAC_SHIFT;
    q   = sh[DATA_WIDTH-1:0];
    sat = 1'b0;
`ifdef ACC_DRAIN_RELU_EN
    if (sh < 0) begin
      q = '0;
    end else if (sh > QMAX) begin
      q   = QMAX[DATA_WIDTH-1:0];
      sat = 1'b1;
    end
`else
    if (sh > QMAX) begin
      q   = QMAX[DATA_WIDTH-1:0];
      sat = 1'b1;
    end else if (sh < QMIN) begin
      q   = QMIN[DATA_WIDTH-1:0];
      sat = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/acc_drain.sv
// Captures PE accumulators and drains them one requantized word per handshake.
// ACC_DRAIN_RELU_EN selects ReLU clamping of negative words.
module acc_drain
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_PE     = NUM_PE_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_PE*2*DATA_WIDTH-1:0] acc_in,
  output logic                         clear_acc,
  output logic                         busy,
  acc_drain_if.master                  dout,
  output logic                         sat_flag,
  output logic                         done
);

  localparam int LW = 2*DATA_WIDTH;
  localparam int IW = $clog2(NUM_PE);

  state_e state;
  state_e state_nx;

  logic [LW-1:0]         lanes [NUM_PE];
  logic [IW-1:0]         idx;
  logic                  valid;
  logic                  last;
  logic                  hs;
  logic                  capture;
  logic                  finish;
  logic                  sat_q;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_sat;

  assign valid   = (state == DRAIN);
  assign last    = (idx == IW'(NUM_PE-1));
  assign hs      = valid & dout.out_ready;
  assign capture = (state == IDLE) & start;
  assign finish  = hs & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start)  state_nx = DRAIN;
      DRAIN: if (finish) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PE; i++) lanes[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_PE; i++)
        lanes[i] <= acc_in[i*LW +: LW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx <= '0;
    else if (capture) idx <= '0;
    else if (hs)      idx <= idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_acc <= 1'b0;
      done      <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      clear_acc <= capture;
      done      <= finish;
      if (capture)            sat_q <= 1'b0;
      else if (valid & q_sat) sat_q <= 1'b1;
    end
  end

  acc_requant #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_requant (
    .acc (lanes[idx]),
    .q   (q),
    .sat (q_sat)
  );

  // Sticky flag also reflects the word on the bus right now
  assign sat_flag       = sat_q | (valid & q_sat);
  assign busy           = valid;
  assign dout.out_valid = valid;
  assign dout.out_data  = valid ? q : '0;
  assign dout.out_index = valid ? idx : '0;
  assign dout.out_last  = valid & last;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: vector table of lanes, scoreboard on the output stream.
module tb_acc_drain;
  import npu_pkg::*;

  localparam int DW = 16;
  localparam int NP = 8;
  localparam int LW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NP*LW-1:0] acc_in = '0;
  logic            clear_acc;
  logic            busy;
  logic            sat_flag;
  logic            done;

  acc_drain_if #(.DATA_WIDTH(DW), .NUM_PE(NP)) bus();

  acc_drain #(
    .DATA_WIDTH(DW),
    .NUM_PE(NP),
    .FRAC_SHIFT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .acc_in(acc_in),
    .clear_acc(clear_acc),
    .busy(busy),
    .dout(bus),
    .sat_flag(sat_flag),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [15:0] exp_lin;
    logic [15:0] exp_relu;
    bit          sat_lin;
    bit          sat_relu;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  idx;
    bit          last;
  } exp_t;

  vec_t tbl [24];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_hs_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_of(input int i);
`ifdef ACC_DRAIN_RELU_EN
    return tbl[i].exp_relu;
`else
    return tbl[i].exp_lin;
`endif
  endfunction

  function automatic bit sat_of(input int i);
`ifdef ACC_DRAIN_RELU_EN
    return tbl[i].sat_relu;
`else
    return tbl[i].sat_lin;
`endif
  endfunction

  exp_t e;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: extra word %0h idx %0d",
                 bus.out_data, bus.out_index);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_index", bus.out_index, e.idx);
        chk("out_last", bus.out_last, e.last);
      end
      if (bus.out_last) last_hs_cyc = cyc;
    end
  end

  task automatic begin_drain(input int base);
    for (int i = 0; i < NP; i++) acc_in[i*LW +: LW] = tbl[base+i].acc;
    bus.out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NP; i++)
      sb.push_back('{exp_of(base+i), 3'(i), (i == NP-1)});
    chk("clear_acc_pulse", clear_acc, 1);
    chk("valid_busy_lat1", {busy, bus.out_valid}, 2'b11);
    chk("sat_cleared", sat_flag, 0);
  endtask

  task automatic run_drain(input int base, input int mode);
    bit          sat_e = 1'b0;
    bit          fin = 1'b0;
    int          stalls = 0;
    logic [15:0] hd = '0;
    logic [2:0]  hi = '0;
    for (int i = 0; i < NP; i++) sat_e |= sat_of(base+i);
    begin_drain(base);
    for (int c = 0; c < 400 && !fin; c++) begin
      start = 1'b0;
      case (mode)
        1: bus.out_ready = c[0];
        2: begin
          if (bus.out_valid && bus.out_index == 3'd4 && stalls <= 5) begin
            if (stalls == 0) begin
              hd = bus.out_data;
              hi = bus.out_index;
            end else begin
              chk("stall_hold", {bus.out_data, bus.out_index}, {hd, hi});
            end
            bus.out_ready = (stalls == 5);
            stalls++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        3: begin
          bus.out_ready = 1'b1;
          if (c == 2) begin
            acc_in = {NP{32'h1357_9BDF}};
            start = 1'b1;
          end
          if (bus.out_last) start = 1'b1;
        end
        default: bus.out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      if (c == 0) chk("clear_acc_once", clear_acc, 0);
      if (mode == 3 && c == 2)
        chk("start_ignored", {clear_acc, busy}, 2'b01);
      if (done) fin = 1'b1;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: done never seen, base %0d", base);
    end
    chk("done_after_last", cyc, last_hs_cyc + 1);
    chk("idle_after_done", {busy, bus.out_valid, clear_acc}, 0);
    chk("sat_flag", sat_flag, sat_e);
    chk("sb_empty", sb.size(), 0);
    start = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("sat_sticky", sat_flag, sat_e);
  endtask

  initial begin
    tbl[0]  = '{32'h0001_8000, 16'h0180, 16'h0180, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FF7F, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};
    tbl[3]  = '{32'h8000_0000, 16'h8000, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{32'h0000_0080, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{32'hFFFF_FF80, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{32'h007F_FF7F, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_017F, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[9]  = '{32'h0080_0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};
    tbl[10] = '{32'hFF80_0000, 16'h8000, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{32'hFF7F_FF7F, 16'h8000, 16'h0000, 1'b1, 1'b0};
    tbl[12] = '{32'h0000_0180, 16'h0002, 16'h0002, 1'b0, 1'b0};
    tbl[13] = '{32'hFFFF_FE80, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{32'h1234_5678, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};
    tbl[15] = '{32'h0000_7F7F, 16'h007F, 16'h007F, 1'b0, 1'b0};
    for (int i = 0; i < NP; i++)
      tbl[16+i] = '{32'(i*256), 16'(i), 16'(i), 1'b0, 1'b0};

    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {clear_acc, busy, bus.out_valid, bus.out_data, bus.out_index,
         bus.out_last, sat_flag, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_drain(0, 0);
    run_drain(8, 1);
    run_drain(0, 2);
    run_drain(8, 3);

    begin_drain(0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (bus.out_valid && bus.out_index == 3'd3) break;
      @(posedge clk); #1;
    end
    chk("reached_lane3", {bus.out_valid, bus.out_index}, {1'b1, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_drain",
        {clear_acc, busy, bus.out_valid, bus.out_data, bus.out_index,
         bus.out_last, sat_flag, done}, 0);
    sb.delete();
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_drain(16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 16, output word width (Q8.8).
REQ-002 Parameter NUM_PE, default 8, number of accumulator lanes captured; minimum 2.
REQ-003 Parameter FRAC_SHIFT, default 8, right-shift converting Q16.16 accumulator to Q8.8.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to capture all lanes and begin draining.
REQ-007 acc_in  input  NUM_PE*2*DATA_WIDTH  packed lane accumulators; lane i occupies bits [i*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-008 clear_acc  output  1  one-cycle pulse telling upstream PEs to clear their accumulators.
REQ-009 busy  output  1  high from the capture until the last word is accepted.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-012 out_data  output  DATA_WIDTH  requantized lane value.
REQ-013 out_index  output  $clog2(NUM_PE)  lane number of out_data.
REQ-014 out_last  output  1  high with the word for lane NUM_PE-1.
REQ-015 sat_flag  output  1  sticky; set when any word of the current drain saturated.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and DRAIN.
REQ-018 In IDLE, start SHALL capture all NUM_PE lanes into an internal buffer on that edge, clear sat_flag, set out_index to 0, and enter DRAIN.
REQ-019 clear_acc SHALL be high only in the cycle after the capture edge, for exactly one cycle.
REQ-020 out_valid and busy SHALL be high from the cycle after the capture edge (latency 1) through the cycle of the final handshake.
REQ-021 start SHALL be ignored while in DRAIN; the buffer SHALL NOT change during DRAIN.
REQ-022 While out_valid is high and out_ready is low, out_data, out_index and out_last SHALL be held stable.
REQ-023 On each handshake, out_index SHALL increment by 1 and out_data SHALL present the next lane in the following cycle, with no bubble.
REQ-024 A handshake with out_last high SHALL return the FSM to IDLE, drop out_valid and busy, and pulse done in the next cycle.
REQ-025 Requantization: q = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, signed, computed in at least 2*DATA_WIDTH+1 bits, so rounding is half toward +infinity with no intermediate overflow.
REQ-026 If q is above 2^(DATA_WIDTH-1)-1 or below -2^(DATA_WIDTH-1), out_data SHALL clamp to that limit and sat_flag SHALL set when the word is presented.
REQ-027 sat_flag SHALL stay set until the next accepted start.
REQ-028 A start arriving in the same cycle as the final handshake SHALL be ignored.

Reset
REQ-029 Asserting rst_n low SHALL, at any time including mid-drain, force IDLE, clear the buffer, and drive all outputs (clear_acc, busy, out_valid, out_data, out_index, out_last, sat_flag, done) to 0.

Configuration
REQ-030 If ACC_DRAIN_RELU_EN is defined, any negative q SHALL output 0 and SHALL NOT set sat_flag; positive saturation is unchanged.
REQ-031 If ACC_DRAIN_RELU_EN is not defined, negative values SHALL pass through signed with saturation as in REQ-026.

Structure
REQ-032 Shared package npu_pkg SHALL hold the default DATA_WIDTH, FRAC_SHIFT and the FSM state encoding constants.
REQ-033 Requantization SHALL be a combinational sub-module named acc_requant (acc in, q out, sat out), instantiated once on the selected lane.

Verification
REQ-034 Reset, then start with lane0=0x0001_8000 and lane1=0xFFFF_FF7F, out_ready=1 -> clear_acc pulses 1 cycle after the capture edge; out_data=0x0180 and then 0xFFFF (no RELU) or 0x0000 (RELU).
REQ-035 lane2=0x7FFF_FFFF, lane3=0x8000_0000 -> out_data=0x7FFF and 0x8000 (0x0000 under RELU); sat_flag=1 (RELU: set by lane2 only).
REQ-036 Hold out_ready=0 for 5 cycles on lane 4 -> out_data and out_index stay constant; toggle out_ready every cycle -> all NUM_PE lanes delivered in order with none dropped or duplicated.
REQ-037 Change acc_in and pulse start during DRAIN -> output is unaffected, the original captured values drain, and done pulses exactly once after out_last is accepted.
REQ-038 Assert rst_n low at lane 3 of a drain -> all outputs 0 immediately; the next start drains lanes 0..NUM_PE-1 correctly and sat_flag is cleared.
